// File: rtl/nvme_cmd_engine.sv
// nvme_cmd_engine
//   Buffers 128-bit PCIe command beats in a CMD_DEPTH-entry FIFO and runs them
//   one at a time against the SSD with a req/ack handshake. Each command ends
//   in a tagged 128-bit completion on the PCIe TX stream, which waits for
//   pcie_tx_ready.
//
//   Optional feature: define NVME_TIMEOUT_EN to enable an SSD ack watchdog of
//   TIMEOUT_CYC cycles. On expiry the request is aborted with status 8'h02.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   pcie_rx_data/valid/ready    command beats in: [7:0] op, [15:8] cid,
//                               [63:32] addr, [127:96] wdata
//   ssd_addr, ssd_data_out      request address / write data
//   ssd_write_enable            write request, held until ack
//   ssd_read_enable             read request, held until ack
//   ssd_data_in, ssd_ack        read data and request completion
//   pcie_tx_data/valid/ready    completion out: [127:96] rdata, [16] is_write,
//                               [15:8] cid, [7:0] status
//   err_count                   saturating count of completions with non-zero status
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for the FIFO to hold a command; pops the head
// EXEC  | SSD request asserted, waiting for ack (or watchdog expiry)
// RESP  | completion presented, waiting for pcie_tx_ready
module nvme_cmd_engine #(
  parameter int CMD_DEPTH   = 4,
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [127:0]      pcie_rx_data,
  input  logic              pcie_rx_valid,
  output logic              pcie_rx_ready,
  output logic [ADDR_W-1:0] ssd_addr,
  output logic [DATA_W-1:0] ssd_data_out,
  output logic              ssd_write_enable,
  output logic              ssd_read_enable,
  input  logic [DATA_W-1:0] ssd_data_in,
  input  logic              ssd_ack,
  output logic [127:0]      pcie_tx_data,
  output logic              pcie_tx_valid,
  input  logic              pcie_tx_ready,
  output logic [7:0]        err_count
);

  localparam int PTR_W = $clog2(CMD_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [7:0] OP_READ  = 8'h01;
  localparam logic [7:0] OP_WRITE = 8'h02;

  localparam logic [7:0] ST_OK      = 8'h00;
  localparam logic [7:0] ST_INVALID = 8'h01;
  localparam logic [7:0] ST_TIMEOUT = 8'h02;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t state_q, state_d;

  // ---------------------------------------------------------------- FIFO
  logic [7:0]        mem_op    [CMD_DEPTH];
  logic [7:0]        mem_cid   [CMD_DEPTH];
  logic [ADDR_W-1:0] mem_addr  [CMD_DEPTH];
  logic [DATA_W-1:0] mem_wdata [CMD_DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push, pop;

  assign pcie_rx_ready = (count != CNT_W'(CMD_DEPTH));
  assign push          = pcie_rx_valid && pcie_rx_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < CMD_DEPTH; i++) begin
        mem_op[i]    <= '0;
        mem_cid[i]   <= '0;
        mem_addr[i]  <= '0;
        mem_wdata[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_op[wr_ptr]    <= pcie_rx_data[7:0];
        mem_cid[wr_ptr]   <= pcie_rx_data[15:8];
        mem_addr[wr_ptr]  <= pcie_rx_data[32 +: ADDR_W];
        mem_wdata[wr_ptr] <= pcie_rx_data[96 +: DATA_W];
        wr_ptr            <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // ------------------------------------------------- command / response regs
  logic [7:0]        cmd_op, cmd_cid;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [7:0]        status_q, status_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              cmd_is_write, cmd_is_read;
  logic              head_valid_op;
  logic              timeout_hit;

  assign cmd_is_write  = (cmd_op == OP_WRITE);
  assign cmd_is_read   = (cmd_op == OP_READ);
  assign head_valid_op = (mem_op[rd_ptr] == OP_READ) || (mem_op[rd_ptr] == OP_WRITE);

`ifdef NVME_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMR_W-1:0] tmr_q;

  // Held at zero outside EXEC, so every EXEC entry starts a fresh count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 tmr_q <= '0;
    else if (state_q != S_EXEC) tmr_q <= '0;
    else if (!ssd_ack)          tmr_q <= tmr_q + TMR_W'(1);
  end

  // The count reaches TIMEOUT_CYC at the end of this cycle, so the request
  // is visible for exactly TIMEOUT_CYC cycles.
  assign timeout_hit = (tmr_q == TMR_W'(TIMEOUT_CYC - 1));

  logic unused_bits;
  assign unused_bits = ^pcie_rx_data;
`else
  assign timeout_hit = 1'b0;

  logic unused_bits;
  assign unused_bits = ^{pcie_rx_data, 32'(TIMEOUT_CYC)};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cmd_op    <= '0;
      cmd_cid   <= '0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      status_q  <= '0;
      rdata_q   <= '0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      rdata_q  <= rdata_d;
      if (pop) begin
        cmd_op    <= mem_op[rd_ptr];
        cmd_cid   <= mem_cid[rd_ptr];
        cmd_addr  <= mem_addr[rd_ptr];
        cmd_wdata <= mem_wdata[rd_ptr];
      end
    end
  end

  // ------------------------------------------------------------------ FSM
  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    rdata_d  = rdata_q;
    pop      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (count != '0) begin
          pop = 1'b1;
          if (head_valid_op) begin
            state_d = S_EXEC;
          end else begin
            status_d = ST_INVALID;
            rdata_d  = '0;
            state_d  = S_RESP;
          end
        end
      end
      S_EXEC: begin
        // An ack coinciding with watchdog expiry is a normal completion.
        if (ssd_ack) begin
          status_d = ST_OK;
          rdata_d  = cmd_is_read ? ssd_data_in : '0;
          state_d  = S_RESP;
        end else if (timeout_hit) begin
          status_d = ST_TIMEOUT;
          rdata_d  = '0;
          state_d  = S_RESP;
        end
      end
      S_RESP: begin
        if (pcie_tx_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (state_q == S_RESP && pcie_tx_ready &&
                 status_q != ST_OK && err_count != 8'hFF) begin
      err_count <= err_count + 8'd1;
    end
  end

  // -------------------------------------------------------------- outputs
  assign ssd_write_enable = (state_q == S_EXEC) && cmd_is_write;
  assign ssd_read_enable  = (state_q == S_EXEC) && cmd_is_read;
  assign ssd_addr         = (state_q == S_EXEC) ? cmd_addr : '0;
  assign ssd_data_out     = ssd_write_enable ? cmd_wdata : '0;

  assign pcie_tx_valid = (state_q == S_RESP);
  assign pcie_tx_data  = pcie_tx_valid ?
                         {32'(rdata_q), 79'd0, cmd_is_write, cmd_cid, status_q} :
                         128'd0;

endmodule
